// File: rtl/regfile_bus_arbiter.sv
// Round-robin arbiter that sequences single-beat requests onto the register-file bus:
// accept in IDLE, one registered bus cycle in ACCESS, a one-cycle response in RESP.
module regfile_bus_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16,
   localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          rsp_err,
   output logic [ADDR_WIDTH-1:0]         addr,
   output logic                          chip_select,
   output logic                          write_en,
   output logic                          read_en,
   output logic [DATA_WIDTH-1:0]         write_data,
   input  logic [DATA_WIDTH-1:0]         read_data,
   input  logic                          data_valid,
   output logic                          busy,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic [CNT_WIDTH-1:0]          txn_count
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                state_reg, state_next;
   logic [ID_WIDTH-1:0]   rr_ptr_reg;
   logic [ID_WIDTH-1:0]   win_id;
   logic                  win_found;
   logic [ID_WIDTH:0]     cand;
   logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
   logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // First pending requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr_reg} + (ID_WIDTH+1)'(k);
         if (cand >= (ID_WIDTH+1)'(NUM_REQ))
            cand = cand - (ID_WIDTH+1)'(NUM_REQ);
         if (!win_found && req_valid[cand[ID_WIDTH-1:0]]) begin
            win_found = 1'b1;
            win_id    = cand[ID_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      req_ready  = '0;
      rsp_valid  = '0;
      case (state_reg)
         IDLE: begin
            if (win_found) begin
               req_ready[win_id] = 1'b1;
               state_next        = ACCESS;
            end
         end
         ACCESS: state_next = RESP;
         RESP: begin
            rsp_valid[grant_id] = 1'b1;
            state_next          = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state_reg != IDLE);

   // The bus registers double as the request latch for the single ACCESS cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_reg  <= '0;
         grant_id    <= '0;
         txn_count   <= '0;
         chip_select <= 1'b0;
         write_en    <= 1'b0;
         read_en     <= 1'b0;
         addr        <= '0;
         write_data  <= '0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (win_found) begin
                  grant_id    <= win_id;
                  chip_select <= 1'b1;
                  write_en    <= req_write[win_id];
                  read_en     <= ~req_write[win_id];
                  addr        <= addr_arr[win_id];
                  write_data  <= req_write[win_id] ? wdata_arr[win_id] : '0;
               end
            end
            ACCESS: begin
               chip_select <= 1'b0;
               write_en    <= 1'b0;
               read_en     <= 1'b0;
               addr        <= '0;
               write_data  <= '0;
               if (read_en) begin
                  rsp_rdata <= data_valid ? read_data : '0;
                  rsp_err   <= ~data_valid;
               end else begin
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
               end
            end
            RESP: begin
               rr_ptr_reg <= (grant_id == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
               txn_count  <= txn_count + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_bus_arbiter.sv
// Randomized bench for regfile_bus_arbiter against a transaction-level model
// (accept at T, bus at T+1, response at T+2, round-robin from the last owner).
module tb_regfile_bus_arbiter;
   localparam int NUM_REQ    = 3;
   localparam int ADDR_WIDTH = 8;
   localparam int DATA_WIDTH = 32;
   localparam int CNT_WIDTH  = 16;
   localparam int ID_WIDTH   = $clog2(NUM_REQ);

   logic                          clk = 1'b0;
   logic                          rst;
   logic [NUM_REQ-1:0]            req_valid, req_write, req_ready, rsp_valid;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [DATA_WIDTH-1:0]         rsp_rdata, write_data, read_data;
   logic                          rsp_err, chip_select, write_en, read_en, data_valid, busy;
   logic [ADDR_WIDTH-1:0]         addr;
   logic [ID_WIDTH-1:0]           grant_id;
   logic [CNT_WIDTH-1:0]          txn_count;

   always #5 clk = ~clk;

   regfile_bus_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .addr(addr), .chip_select(chip_select), .write_en(write_en), .read_en(read_en),
      .write_data(write_data), .read_data(read_data), .data_valid(data_valid),
      .busy(busy), .grant_id(grant_id), .txn_count(txn_count)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // requester and regfile model state
   bit                    rv [NUM_REQ];
   bit                    rw [NUM_REQ];
   logic [ADDR_WIDTH-1:0] ra [NUM_REQ];
   logic [DATA_WIDTH-1:0] rd [NUM_REQ];
   bit                    waiting [NUM_REQ];
   logic [DATA_WIDTH-1:0] mem [256];
   int                    cyc, free_at, acc_at, ptr, exp_gid, exp_cnt, owner, p_new, p_drop;
   bit                    own_w, exp_err;
   logic [ADDR_WIDTH-1:0] own_a;
   logic [DATA_WIDTH-1:0] own_d, exp_rdata;
   int                    served [$];

   task automatic model_reset();
      for (int i = 0; i < NUM_REQ; i++) begin
         rv[i] = 0; waiting[i] = 0;
      end
      cyc = 0; free_at = 0; acc_at = -10; ptr = 0; exp_gid = 0; exp_cnt = 0;
      served.delete();
   endtask

   task automatic drive_requesters();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!waiting[i]) begin
            if (rv[i]) begin
               if ($urandom_range(99) < p_drop) rv[i] = 0;
            end else if ($urandom_range(99) < p_new) begin
               rv[i] = 1; rw[i] = 1'($urandom_range(1));
               ra[i] = ADDR_WIDTH'($urandom); rd[i] = $urandom;
            end
         end
         req_valid[i] = rv[i];
         req_write[i] = rv[i] ? rw[i] : 1'($urandom_range(1));
         req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]  = rv[i] ? ra[i] : ADDR_WIDTH'($urandom);
         req_wdata[i*DATA_WIDTH +: DATA_WIDTH] = rv[i] ? rd[i] : $urandom;
      end
   endtask

   // One clock cycle: call just after a falling edge.
   task automatic cycle_body();
      logic [NUM_REQ-1:0] exp_ready, exp_rsp;
      int w, idx;
      bit dv;
      drive_requesters();
      exp_ready = '0; w = -1;
      if (cyc >= free_at)
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = (ptr + k) % NUM_REQ;
            if (w < 0 && rv[idx]) w = idx;
         end
      if (w >= 0) exp_ready[w] = 1'b1;
      dv = ($urandom_range(99) < 75);
      data_valid = dv;
      read_data  = $urandom;
      if (cyc == acc_at + 1 && !own_w && dv) read_data = mem[own_a];
      #1;
      check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
      check_eq("busy", 64'(busy), 64'(cyc == acc_at + 1 || cyc == acc_at + 2));
      check_eq("grant_id", 64'(grant_id), 64'(exp_gid));
      check_eq("txn_count", 64'(txn_count), 64'(exp_cnt));
      if (cyc == acc_at + 1) begin
         check_eq("bus_access", {chip_select, write_en, read_en, addr, write_data},
                  {1'b1, own_w, !own_w, own_a, (own_w ? own_d : 32'h0)});
         exp_rdata = (!own_w && dv) ? mem[own_a] : 32'h0;
         exp_err   = !own_w && !dv;
      end else begin
         check_eq("bus_quiet", {chip_select, write_en, read_en, addr, write_data}, 64'h0);
      end
      if (cyc == acc_at + 2) begin
         exp_rsp = '0; exp_rsp[owner] = 1'b1;
         check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
         check_eq("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
         check_eq("rsp_err", 64'(rsp_err), 64'(exp_err));
         $display("txn %0d: req%0d %s addr=0x%02h data=0x%08h err=%0d", exp_cnt, owner,
                  own_w ? "WR" : "RD", own_a, own_w ? own_d : rsp_rdata, rsp_err);
         if (own_w) mem[own_a] = own_d;
         waiting[owner] = 0;
         ptr = (owner + 1) % NUM_REQ;
         exp_cnt = (exp_cnt + 1) % (1 << CNT_WIDTH);
         served.push_back(owner);
      end else begin
         check_eq("rsp_quiet", 64'(rsp_valid), 64'h0);
      end
      if (w >= 0) begin
         owner = w; own_w = rw[w]; own_a = ra[w]; own_d = rd[w];
         acc_at = cyc; free_at = cyc + 3; exp_gid = w;
         rv[w] = 0; waiting[w] = 1;
      end
      cyc++;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_strobes"}, {req_ready, rsp_valid, chip_select, write_en, read_en, busy}, 64'h0);
      check_eq({tag, "_bus"}, {addr, write_data}, 64'h0);
      check_eq({tag, "_rsp"}, {rsp_rdata, rsp_err}, 64'h0);
      check_eq({tag, "_gid_cnt"}, {grant_id, txn_count}, 64'h0);
   endtask

   initial begin
      bit hit;
      rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      read_data = '0; data_valid = 1'b0;
      for (int a = 0; a < 256; a++) mem[a] = $urandom;
      model_reset();
      repeat (3) @(negedge clk);
      #1 check_reset_outputs("reset");

      // Fairness: all requesters pending from reset release.
      p_new = 100; p_drop = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rv[i] = 1; rw[i] = 1'($urandom_range(1)); ra[i] = ADDR_WIDTH'($urandom); rd[i] = $urandom;
      end
      @(negedge clk); rst = 1'b0; cycle_body();
      repeat (18) begin @(negedge clk); cycle_body(); end
      check_eq("fair_count", 64'(served.size() >= 6), 64'h1);
      for (int i = 0; i < 6 && i < served.size(); i++)
         check_eq("fair_order", 64'(served[i]), 64'(i % NUM_REQ));

      // Randomized traffic with drops and missing acknowledges.
      p_new = 35; p_drop = 8;
      repeat (2000) begin @(negedge clk); cycle_body(); end

      // Reset during ACCESS, then req0 and req2 pending.
      p_new = 100; p_drop = 0; hit = 0;
      for (int t = 0; t < 50 && !hit; t++) begin
         @(negedge clk); cycle_body();
         hit = (acc_at == cyc - 1);
      end
      check_eq("mid_reset_wait", 64'(hit), 64'h1);
      @(negedge clk); #1;
      check_eq("pre_reset_cs", 64'(chip_select), 64'(hit));
      rst = 1'b1; req_valid = '0;
      #1 check_reset_outputs("async_reset");
      @(negedge clk); #1 check_reset_outputs("held_reset");
      model_reset();
      p_new = 0; p_drop = 0;
      for (int i = 0; i < NUM_REQ; i += 2) begin
         rv[i] = 1; rw[i] = 1'b0; ra[i] = ADDR_WIDTH'($urandom); rd[i] = $urandom;
      end
      @(negedge clk); rst = 1'b0; cycle_body();
      repeat (8) begin @(negedge clk); cycle_body(); end
      check_eq("post_reset_count", 64'(served.size()), 64'h2);
      if (served.size() == 2) begin
         check_eq("post_reset_first", 64'(served[0]), 64'h0);
         check_eq("post_reset_second", 64'(served[1]), 64'h2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
